// File: rtl/spi_cfg_master.sv
// SPI mode-0 configuration master: streams MSB-first words in CS-framed bursts.
// Define SPI_CFG_CRC_EN to append a CRC-8 (poly 0x07) byte after the last word of each burst.
`timescale 1ns/1ps
module spi_cfg_master #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  input  logic                  tx_last,
  output logic                  tx_ready,
  output logic                  SCK,
  output logic                  CS,
  output logic                  MOSI,
  output logic                  busy,
  output logic                  done
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] WORD_BITS = BIT_W'(DATA_WIDTH);
`ifdef SPI_CFG_CRC_EN
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] CRC_LEN  = BIT_W'(8);
`endif

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, WAIT_NEXT, HOLD
`ifdef SPI_CFG_CRC_EN
    , CRC
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  sck_q, sck_d;
  logic                  cs_q, cs_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  last_q, last_d;
`ifdef SPI_CFG_CRC_EN
  logic [7:0]            crc_q, crc_d, crc_upd;
`endif

  logic div_term, timed, shifting, bits_done;

  always_comb begin
    div_term = (div_q == DIV_LAST);
    timed    = (state_q != IDLE) && (state_q != WAIT_NEXT);
`ifdef SPI_CFG_CRC_EN
    shifting  = (state_q == SHIFT) || (state_q == CRC);
    bits_done = (state_q == CRC) ? (bit_q == CRC_LEN) : (bit_q == WORD_BITS);
    // MOSI at a falling edge is exactly the bit the slave sampled on the preceding rise.
    crc_upd   = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ mosi_q) ? 8'h07 : 8'h00);
`else
    shifting  = (state_q == SHIFT);
    bits_done = (bit_q == WORD_BITS);
`endif
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sck_q   <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
`ifdef SPI_CFG_CRC_EN
      crc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sck_q   <= sck_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      last_q  <= last_d;
`ifdef SPI_CFG_CRC_EN
      crc_q   <= crc_d;
`endif
    end
  end

  // The low half-period after the final falling edge stays in SHIFT, giving (2*N+2)*CLK_DIV CS-low.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, WAIT_NEXT: if (tx_valid) state_d = SETUP;
      SETUP:           if (div_term) state_d = SHIFT;
      SHIFT: begin
        if (div_term && !sck_q && bits_done) state_d = last_q ? HOLD : WAIT_NEXT;
`ifdef SPI_CFG_CRC_EN
        if (div_term && sck_q && last_q && (bit_q == LAST_BIT)) state_d = CRC;
`endif
      end
`ifdef SPI_CFG_CRC_EN
      CRC:             if (div_term && !sck_q && bits_done) state_d = HOLD;
`endif
      HOLD:            if (div_term) state_d = IDLE;
      default:         state_d = IDLE;
    endcase
  end

  always_comb begin
    div_d   = (timed && !div_term) ? div_q + 1'b1 : '0;
    bit_d   = bit_q;
    shift_d = shift_q;
    sck_d   = sck_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    last_d  = last_q;
`ifdef SPI_CFG_CRC_EN
    crc_d   = crc_q;
`endif
    case (state_q)
      IDLE, WAIT_NEXT: begin
        if (tx_valid) begin
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = tx_data[DATA_WIDTH-1];
          shift_d = {tx_data[DATA_WIDTH-2:0], 1'b0};
          last_d  = tx_last;
          bit_d   = '0;
`ifdef SPI_CFG_CRC_EN
          if (state_q == IDLE) crc_d = '0;
`endif
        end
      end
      SETUP: if (div_term) sck_d = 1'b1;
      HOLD: begin
        if (div_term) begin
          cs_d   = 1'b1;
          busy_d = 1'b0;
          done_d = 1'b1;
          mosi_d = 1'b0;
        end
      end
      default: begin
        if (shifting && div_term) begin
          if (sck_q) begin
            sck_d   = 1'b0;
            bit_d   = bit_q + 1'b1;
            mosi_d  = shift_q[DATA_WIDTH-1];
            shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
`ifdef SPI_CFG_CRC_EN
            if (state_q == SHIFT) begin
              crc_d = crc_upd;
              if (last_q && (bit_q == LAST_BIT)) begin
                mosi_d  = crc_upd[7];
                shift_d = {crc_upd[6:0], {(DATA_WIDTH-7){1'b0}}};
                bit_d   = '0;
              end
            end
`endif
          end else if (!bits_done) begin
            sck_d = 1'b1;
          end
        end
      end
    endcase
    tx_ready = (state_q == IDLE) || (state_q == WAIT_NEXT);
  end

  assign SCK  = sck_q;
  assign CS   = cs_q;
  assign MOSI = mosi_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed bench for spi_cfg_master: vector table of single-word bursts plus gap, held-valid and abort sequences.
`timescale 1ns/1ps
module tb_spi_cfg_master;
  localparam int DW = 16;
  localparam int CD = 4;
`ifdef SPI_CFG_CRC_EN
  localparam int CRC_BITS   = 8;
  localparam int EXP_CS_LOW = 200;
`else
  localparam int CRC_BITS   = 0;
  localparam int EXP_CS_LOW = 136;
`endif
  localparam int EXP_READY_WAIT = 132;
  localparam int LIMIT = 2000;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_last = 1'b0;
  logic          tx_ready, SCK, CS, MOSI, busy, done;

  always #5 sys_clk = ~sys_clk;

  spi_cfg_master #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .SCK      (SCK),
    .CS       (CS),
    .MOSI     (MOSI),
    .busy     (busy),
    .done     (done)
  );

  int total = 0;
  int bad = 0;

  // Slave-side monitor sampled on the falling sys_clk edge.
  logic [63:0] rx = '0;
  int rx_bits = 0, rise_cnt = 0, done_cnt = 0, mosi_viol = 0, sck_idle_viol = 0;
  int cs_low_run = 0, cs_high_run = 0, last_low_len = 0, last_high_len = 0, cs_rise_cnt = 0;
  logic sck_prev = 1'b0, mosi_prev = 1'b0;

  always @(negedge sys_clk) begin
    if (SCK && !sck_prev) begin
      rise_cnt <= rise_cnt + 1;
      if (!CS) begin
        rx      <= {rx[62:0], MOSI};
        rx_bits <= rx_bits + 1;
      end
    end
    if ((MOSI !== mosi_prev) && SCK) mosi_viol <= mosi_viol + 1;
    if (SCK && CS) sck_idle_viol <= sck_idle_viol + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (CS === 1'b0) begin
      if (cs_high_run > 0) last_high_len <= cs_high_run;
      cs_high_run <= 0;
      cs_low_run  <= cs_low_run + 1;
    end else begin
      if (cs_low_run > 0) begin
        last_low_len <= cs_low_run;
        cs_rise_cnt  <= cs_rise_cnt + 1;
      end
      cs_low_run  <= 0;
      cs_high_run <= cs_high_run + 1;
    end
    sck_prev  <= SCK;
    mosi_prev <= MOSI;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l, output int waited);
    tx_data  = d;
    tx_valid = 1'b1;
    tx_last  = l;
    waited   = 0;
    while (!tx_ready && waited < LIMIT) begin
      @(negedge sys_clk);
      waited++;
    end
    chk("handshake_ready", tx_ready, 1'b1);
    @(negedge sys_clk);
    tx_valid = 1'b0;
    tx_last  = 1'b0;
  endtask

  task automatic wait_done();
    int cycles;
    cycles = 0;
    do begin
      @(negedge sys_clk);
      cycles++;
    end while (!done && cycles < LIMIT);
    chk("done_seen", done, 1'b1);
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic [63:0]   exp_rx;
    int            exp_bits;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int w, w2, b0, d0, r0, cr0, k, n, gap_bad;
    logic [63:0] mask;

`ifdef SPI_CFG_CRC_EN
    vecs.push_back('{16'h0001, 64'h00_0107, 24});
    vecs.push_back('{16'h0100, 64'h01_0015, 24});
    vecs.push_back('{16'h0000, 64'h00_0000, 24});
    vecs.push_back('{16'h00FF, 64'h00_FFF3, 24});
`else
    vecs.push_back('{16'hA5C3, 64'hA5C3, 16});
    vecs.push_back('{16'h00FF, 64'h00FF, 16});
    vecs.push_back('{16'h8001, 64'h8001, 16});
    vecs.push_back('{16'h0000, 64'h0000, 16});
    vecs.push_back('{16'hFFFF, 64'hFFFF, 16});
`endif

    // Reset and idle
    @(negedge sys_clk);
    chk("reset_state", {CS, SCK, MOSI, tx_ready, busy, done}, 6'b100100);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      chk("idle", {CS, SCK, MOSI, tx_ready, busy, done}, 6'b100100);
    end
    #1;

    // Single-word bursts, each started in the done cycle of the previous one
    for (int i = 0; i < vecs.size(); i++) begin
      b0 = rx_bits;
      d0 = done_cnt;
      send(vecs[i].data, 1'b1, w);
      wait_done();
      chk("done_cycle_cs_busy", {CS, busy}, 2'b10);
      #1;
      n    = rx_bits - b0;
      mask = (64'd1 << n) - 64'd1;
      chk("vec_nbits", n, vecs[i].exp_bits);
      chk("vec_data", rx & mask, vecs[i].exp_rx);
      chk("vec_cs_low", last_low_len, EXP_CS_LOW);
      chk("vec_done_pulses", done_cnt - d0, 1);
      if (i > 0) chk("vec_cs_high_min", last_high_len, 1);
      $display("burst %0d data=%04h bits=%0d rx=%0h cs_low=%0d", i, vecs[i].data, n, rx & mask, last_low_len);
    end
    repeat (5) @(negedge sys_clk);
    #1;

    // Two words with a 50-cycle stall between them
    b0  = rx_bits;
    d0  = done_cnt;
    cr0 = cs_rise_cnt;
    send(16'h1234, 1'b0, w);
    k = 0;
    while (!tx_ready && k < LIMIT) begin
      @(negedge sys_clk);
      k++;
    end
    chk("gap_reached_wait", tx_ready, 1'b1);
    gap_bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge sys_clk);
      if (CS !== 1'b0 || SCK !== 1'b0 || tx_ready !== 1'b1) gap_bad++;
    end
    chk("gap_cs_sck_low", gap_bad, 0);
    send(16'hBEEF, 1'b1, w);
    wait_done();
    repeat (5) @(negedge sys_clk);
    #1;
    n = rx_bits - b0;
    chk("gap_nbits", n, 32 + CRC_BITS);
    chk("gap_data", (rx >> CRC_BITS) & 64'hFFFF_FFFF, 64'h1234_BEEF);
    chk("gap_done_pulses", done_cnt - d0, 1);
    chk("gap_cs_single_frame", cs_rise_cnt - cr0, 1);
    $display("gap burst bits=%0d rx=%0h", n, rx >> CRC_BITS);

    // tx_valid held through SHIFT: second word waits for WAIT_NEXT and is taken once
    b0 = rx_bits;
    d0 = done_cnt;
    send(16'h1234, 1'b0, w);
    send(16'h5A5A, 1'b1, w2);
    chk("held_ready_wait", w2, EXP_READY_WAIT);
    wait_done();
    repeat (40) @(negedge sys_clk);
    #1;
    n = rx_bits - b0;
    chk("held_nbits", n, 32 + CRC_BITS);
    chk("held_data", (rx >> CRC_BITS) & 64'hFFFF_FFFF, 64'h1234_5A5A);
    chk("held_done_pulses", done_cnt - d0, 1);
    $display("held-valid burst wait=%0d bits=%0d rx=%0h", w2, n, rx >> CRC_BITS);

    // Reset after the 7th SCK rise aborts the burst without a done pulse
    d0 = done_cnt;
    r0 = rise_cnt;
    send(16'hF0F0, 1'b1, w);
    k = 0;
    while ((rise_cnt - r0) < 7 && k < LIMIT) begin
      @(negedge sys_clk);
      #1;
      k++;
    end
    chk("abort_seven_rises", rise_cnt - r0, 7);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    chk("abort_state", {CS, SCK, busy, done, tx_ready}, 5'b10001);
    sys_rst_n = 1'b1;
    repeat (200) @(negedge sys_clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);
    $display("abort after %0d rises", rise_cnt - r0);

    b0 = rx_bits;
    d0 = done_cnt;
    send(16'h00FF, 1'b1, w);
    wait_done();
    #1;
    n    = rx_bits - b0;
    mask = (64'd1 << n) - 64'd1;
    chk("post_abort_nbits", n, 16 + CRC_BITS);
`ifdef SPI_CFG_CRC_EN
    chk("post_abort_data", rx & mask, 64'h00_FFF3);
`else
    chk("post_abort_data", rx & mask, 64'h00FF);
`endif
    chk("post_abort_cs_low", last_low_len, EXP_CS_LOW);
    chk("post_abort_done_pulses", done_cnt - d0, 1);
    $display("post-abort burst bits=%0d rx=%0h", n, rx & mask);

    repeat (5) @(negedge sys_clk);
    #1;
    chk("mosi_stable_while_sck_high", mosi_viol, 0);
    chk("sck_low_while_cs_high", sck_idle_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
